stream_element_extractor: RTL and testbench

//  Downstream of the AXI stream compressor. Consumes its dataOut/dataOutValid byte bus and splits it into stream elements.

---
 rtl/stream_element_pkg.sv | 19 +
 rtl/stream_element_stats.sv | 28 ++
 rtl/stream_element_extractor.sv | 126 ++++++++++++
 tb/tb_stream_element_extractor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_element_pkg.sv
// Shared types for the stream element extractor.
// Record length width matches the default extractor parameters.
package stream_element_pkg;

    localparam logic [7:0] DELIM_BYTE = 8'h2C;
    localparam int REC_LEN_W = 7;

    typedef enum logic {
        SCAN,
        FIXED
    } extract_state_t;

    typedef struct packed {
        logic [REC_LEN_W-1:0] len;
        logic [7:0]           firstByte;
        logic                 err;
    } elem_rec_t;

endpackage

// File: rtl/stream_element_stats.sv
// Element and error counters, built only with STREAM_ELEMENT_STATS_EN.
// Both counters wrap at 2^32 and clear on reset.
`ifdef STREAM_ELEMENT_STATS_EN
module stream_element_stats
    import stream_element_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        elemValid,
    input  logic        elemError,
    output logic [31:0] elemCount,
    output logic [31:0] errCount
);

    always_ff @(posedge clk) begin
        if (reset) begin
            elemCount <= '0;
            errCount  <= '0;
        end else if (elemValid) begin
            elemCount <= elemCount + 32'd1;
            if (elemError) begin
                errCount <= errCount + 32'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/stream_element_extractor.sv
// Splits a compressed byte stream into elements (var field, 2C, fixed field).
// Optional counters via STREAM_ELEMENT_STATS_EN.
module stream_element_extractor
    import stream_element_pkg::*;
#(
    parameter int DATA_BUS_WIDTH_BYTES     = 8,
    parameter int FIXEDFIELD_LENGTH_BYTES  = 17,
    parameter int MAX_VARIABLEFIELD_LENGTH = 16,
    parameter int MAX_STREAMELEMENT_LENGTH =
        MAX_VARIABLEFIELD_LENGTH + FIXEDFIELD_LENGTH_BYTES + 1,
    parameter int LEN_W = $clog2(MAX_STREAMELEMENT_LENGTH + 1) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_BUS_WIDTH_BYTES-1:0][7:0] dataIn,
    input  logic                                 dataInValid,
    output logic                                 elemValid,
    output logic [LEN_W-1:0]                     elemLength,
    output logic [7:0]                           elemFirstByte,
    output logic                                 elemError
`ifdef STREAM_ELEMENT_STATS_EN
    ,
    output logic [31:0]                          elemCount,
    output logic [31:0]                          errCount
`endif
);

    localparam int FIX_W = $clog2(FIXEDFIELD_LENGTH_BYTES + 1);
    localparam logic [FIX_W-1:0] FIX_LOAD = FIX_W'(FIXEDFIELD_LENGTH_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_STREAMELEMENT_LENGTH);

    // A fixed field no shorter than a beat guarantees one element end per beat.
    if (FIXEDFIELD_LENGTH_BYTES < DATA_BUS_WIDTH_BYTES) begin : g_badFix
        $error("FIXEDFIELD_LENGTH_BYTES must be >= DATA_BUS_WIDTH_BYTES");
    end
    if (LEN_W != REC_LEN_W) begin : g_badLen
        $error("LEN_W must equal REC_LEN_W of stream_element_pkg");
    end

    extract_state_t   state, nState;
    logic [LEN_W-1:0] lenCnt, nLen;
    logic [FIX_W-1:0] fixCnt, nFix;
    logic             firstPending, nFirstPending;
    logic [7:0]       firstByte, nFirstByte;
    logic             emptyVar, nEmptyVar;
    logic             done;
    elem_rec_t        rec, elemRec;

    always_comb begin
        nState        = state;
        nLen          = lenCnt;
        nFix          = fixCnt;
        nFirstPending = firstPending;
        nFirstByte    = firstByte;
        nEmptyVar     = emptyVar;
        done          = 1'b0;
        rec           = '0;
        if (dataInValid) begin
            for (int i = 0; i < DATA_BUS_WIDTH_BYTES; i++) begin
                if (nState == SCAN) begin
                    if (nFirstPending) begin
                        nFirstByte    = dataIn[i];
                        nFirstPending = 1'b0;
                    end
                    if (nLen != '1) nLen = nLen + 1'b1;
                    if (dataIn[i] == DELIM_BYTE) begin
                        nState    = FIXED;
                        nFix      = FIX_LOAD;
                        nEmptyVar = (nLen == LEN_W'(1));
                    end
                end else begin
                    if (nLen != '1) nLen = nLen + 1'b1;
                    nFix = nFix - 1'b1;
                    if (nFix == '0) begin
                        done          = 1'b1;
                        rec.len       = nLen;
                        rec.firstByte = nFirstByte;
                        rec.err       = (nLen > MAX_LEN) | nEmptyVar;
                        nState        = SCAN;
                        nLen          = '0;
                        nFirstPending = 1'b1;
                        nEmptyVar     = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SCAN;
            lenCnt       <= '0;
            fixCnt       <= '0;
            firstPending <= 1'b1;
            firstByte    <= '0;
            emptyVar     <= 1'b0;
            elemValid    <= 1'b0;
            elemRec      <= '0;
        end else begin
            state        <= nState;
            lenCnt       <= nLen;
            fixCnt       <= nFix;
            firstPending <= nFirstPending;
            firstByte    <= nFirstByte;
            emptyVar     <= nEmptyVar;
            elemValid    <= done;
            if (done) elemRec <= rec;
        end
    end

    assign elemLength    = elemRec.len;
    assign elemFirstByte = elemRec.firstByte;
    assign elemError     = elemRec.err;

`ifdef STREAM_ELEMENT_STATS_EN
    stream_element_stats u_stats (
        .clk       (clk),
        .reset     (reset),
        .elemValid (elemValid),
        .elemError (elemError),
        .elemCount (elemCount),
        .errCount  (errCount)
    );
`endif

endmodule

// File: tb/tb_stream_element_extractor.sv
// Directed bench for stream_element_extractor.
// Also checks the counters when STREAM_ELEMENT_STATS_EN is defined.
module tb_stream_element_extractor;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [W-1:0][7:0] dataIn;
    logic              dataInValid;
    logic              elemValid;
    logic [6:0]        elemLength;
    logic [7:0]        elemFirstByte;
    logic              elemError;
`ifdef STREAM_ELEMENT_STATS_EN
    logic [31:0]       elemCount;
    logic [31:0]       errCount;
`endif

    stream_element_extractor dut (
        .clk           (clk),
        .reset         (reset),
        .dataIn        (dataIn),
        .dataInValid   (dataInValid),
        .elemValid     (elemValid),
        .elemLength    (elemLength),
        .elemFirstByte (elemFirstByte),
        .elemError     (elemError)
`ifdef STREAM_ELEMENT_STATS_EN
        ,
        .elemCount     (elemCount),
        .errCount      (errCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int varLen;
        int first;
        bit fix2c;
        int expLen;
        int expFirst;
        int expErr;
    } vec_t;

    typedef struct {
        int len;
        int first;
        int err;
    } cap_t;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] bq[$];
    cap_t       cap[$];
    vec_t       tbl[$];

    always @(posedge clk) begin
        #1;
        if (elemValid)
            cap.push_back('{int'(elemLength), int'(elemFirstByte),
                            int'(elemError)});
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic add_elem(input vec_t v);
        if (v.varLen > 0) begin
            bq.push_back(8'(v.first));
            for (int k = 1; k < v.varLen; k++) bq.push_back(8'(8'hA0 + k));
        end
        bq.push_back(8'h2C);
        for (int k = 0; k < 17; k++) begin
            if (v.fix2c || k == 16) bq.push_back(8'h2C);
            else bq.push_back(8'(8'hB0 + k));
        end
    endtask

    task automatic send_beat();
        for (int j = 0; j < W; j++) dataIn[j] = bq.pop_front();
        dataInValid = 1'b1;
        @(posedge clk);
        #1;
        dataInValid = 1'b0;
        dataIn = {W{8'h2C}};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dataInValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_table(input string nm);
        int n;
        int m;
        bq.delete();
        cap.delete();
        foreach (tbl[i]) add_elem(tbl[i]);
        while (bq.size() % W != 0) bq.push_back(8'h00);
        n = 0;
        while (bq.size() > 0) begin
            send_beat();
            n++;
            if (n % 3 == 0) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, " count"}, cap.size(), tbl.size());
        m = (cap.size() < tbl.size()) ? cap.size() : tbl.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s len[%0d]", nm, i), cap[i].len, tbl[i].expLen);
            chk($sformatf("%s first[%0d]", nm, i), cap[i].first,
                tbl[i].expFirst);
            chk($sformatf("%s err[%0d]", nm, i), cap[i].err, tbl[i].expErr);
        end
    endtask

    initial begin
        int lens[20] = '{27, 21, 21, 24, 31, 19, 26, 23, 33, 33,
                         31, 19, 19, 20, 29, 19, 30, 19, 20, 21};
        dataIn = '0;
        dataInValid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", int'(elemValid), 0);
        chk("reset len", int'(elemLength), 0);
        chk("reset first", int'(elemFirstByte), 0);
        chk("reset err", int'(elemError), 0);
        reset = 1'b0;

        // 1: twenty legal elements
        tbl.delete();
        for (int i = 0; i < 20; i++)
            tbl.push_back('{lens[i] - 18, i, 1'b0, lens[i], i, 0});
        run_table("t1");
        do_reset();

        // 2: fixed field full of delimiters
        tbl.delete();
        tbl.push_back('{3, 8'h50, 1'b1, 21, 8'h50, 0});
        tbl.push_back('{2, 8'h51, 1'b1, 20, 8'h51, 0});
        run_table("t2");
        do_reset();

        // 3: delimiter on last byte of a beat, fixed field spans 3 beats
        bq.delete();
        bq.push_back(8'h70);
        for (int k = 1; k < 7; k++) bq.push_back(8'(8'hA0 + k));
        bq.push_back(8'h2C);
        for (int k = 0; k < 17; k++) bq.push_back(8'(8'hB0 + k));
        for (int k = 0; k < 7; k++) bq.push_back(8'h00);
        for (int b = 0; b < 3; b++) begin
            send_beat();
            chk($sformatf("t3 early valid beat%0d", b), int'(elemValid), 0);
        end
        send_beat();
        chk("t3 valid", int'(elemValid), 1);
        chk("t3 len", int'(elemLength), 25);
        chk("t3 first", int'(elemFirstByte), 8'h70);
        chk("t3 err", int'(elemError), 0);
        @(posedge clk);
        #1;
        chk("t3 pulse width", int'(elemValid), 0);
        do_reset();

        // 4: oversize variable field, then a normal element
        tbl.delete();
        tbl.push_back('{20, 8'h60, 1'b0, 38, 8'h60, 1});
        tbl.push_back('{2, 8'h61, 1'b0, 20, 8'h61, 0});
        run_table("t4");
`ifdef STREAM_ELEMENT_STATS_EN
        chk("t4 elemCount", int'(elemCount), 2);
        chk("t4 errCount", int'(errCount), 1);
`endif
        do_reset();

        // 5: empty variable field
        tbl.delete();
        tbl.push_back('{0, 0, 1'b0, 18, 8'h2C, 1});
        tbl.push_back('{1, 8'h62, 1'b0, 19, 8'h62, 0});
        run_table("t5");
        do_reset();

        // 6: reset mid-element, then a clean element
        bq.delete();
        bq.push_back(8'h90);
        for (int k = 1; k < 5; k++) bq.push_back(8'(8'hA0 + k));
        bq.push_back(8'h2C);
        for (int k = 0; k < 10; k++) bq.push_back(8'(8'hB0 + k));
        send_beat();
        send_beat();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 reset valid", int'(elemValid), 0);
        chk("t6 reset len", int'(elemLength), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tbl.delete();
        tbl.push_back('{3, 8'h91, 1'b0, 21, 8'h91, 0});
        run_table("t6");
`ifdef STREAM_ELEMENT_STATS_EN
        chk("t6 elemCount", int'(elemCount), 1);
        chk("t6 errCount", int'(errCount), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
